// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_pkg : RV32I opcodes, control-field encodings, SYSTEM words            |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
package riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
    localparam logic [31:0] WORD_MRET   = 32'h3020_0073;
    localparam logic [31:0] WORD_WFI    = 32'h1050_0073;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_func_t;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        SEL_A_RS1  = 2'd0,
        SEL_A_PC   = 2'd1,
        SEL_A_ZERO = 2'd2
    } alu_sel_a_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        logic [4:0] rd;
        alu_func_t  alu_func;
        alu_sel_a_t alu_sel_a;
        logic       alu_sel_b;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       load;
        logic       store;
        mem_size_t  mem_size;
        logic       mem_signed;
        csr_op_t    csr_op;
        logic       ecall;
        logic       ebreak;
        logic       mret;
        logic       wfi;
        logic       illegal;
    } ctrl_t;

    // alt selects SUB/SRA; callers gate it so ADDI never becomes a subtract.
    function automatic alu_func_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_imm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_imm : immediate extraction and sign extension per instruction format|
// | Rev 1.0    : initial release                                               |
// +----------------------------------------------------------------------------+
module decode_imm
    import riscv_pkg::*;
(
    input  logic [31:7] instruction,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instruction[31]}}, instruction[31:20]};
            IMM_S: imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            IMM_B: imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
            IMM_U: imm = {instruction[31:12], 12'h000};
            IMM_J: imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
            IMM_Z: imm = {27'd0, instruction[19:15]};
            default: imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode : RV32I decode stage, registered control bundle toward execute      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module decode
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit ENABLE_ZICSR = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] next_pc_in,
    input  logic [31:0]     instruction_in,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            invalidate,
    output logic [4:0]      rs1_address,
    output logic [4:0]      rs2_address,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] next_pc_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [31:0]     imm_out,
    output logic [3:0]      alu_func_out,
    output logic [1:0]      alu_sel_a_out,
    output logic            alu_sel_b_out,
    output logic [2:0]      cmp_func_out,
    output logic            branch_out,
    output logic            jump_out,
    output logic            jalr_out,
    output logic            load_out,
    output logic            store_out,
    output logic [1:0]      mem_size_out,
    output logic            mem_signed_out,
    output logic [1:0]      csr_op_out,
    output logic [11:0]     csr_addr_out,
    output logic            ecall_out,
    output logic            ebreak_out,
    output logic            mret_out,
    output logic            wfi_out,
    output logic            illegal_out,
    output logic            valid_out
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    imm_fmt_t    fmt;
    ctrl_t       ctrl;
    logic [31:0] imm;

    ctrl_t            ctrl_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  next_pc_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [31:0]      imm_q;
    logic [2:0]       cmp_q;
    logic [11:0]      csr_addr_q;
    logic             valid_q;

    assign opcode      = instruction_in[6:0];
    assign funct3      = instruction_in[14:12];
    assign funct7      = instruction_in[31:25];
    assign rs1_address = instruction_in[19:15];
    assign rs2_address = instruction_in[24:20];

    decode_imm u_imm (
        .instruction (instruction_in[31:7]),
        .fmt         (fmt),
        .imm         (imm)
    );

    always_comb begin
        ctrl    = '0;
        ctrl.rd = instruction_in[11:7];
        fmt     = IMM_I;
        legal   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal          = 1'b1;
                fmt            = IMM_U;
                ctrl.alu_sel_a = SEL_A_ZERO;
                ctrl.alu_sel_b = 1'b1;
            end
            OPC_AUIPC: begin
                legal          = 1'b1;
                fmt            = IMM_U;
                ctrl.alu_sel_a = SEL_A_PC;
                ctrl.alu_sel_b = 1'b1;
            end
            OPC_JAL: begin
                legal          = 1'b1;
                fmt            = IMM_J;
                ctrl.jump      = 1'b1;
                ctrl.alu_sel_a = SEL_A_PC;
                ctrl.alu_sel_b = 1'b1;
            end
            OPC_JALR: begin
                legal          = (funct3 == 3'b000);
                ctrl.jump      = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.alu_sel_b = 1'b1;
            end
            OPC_BRANCH: begin
                legal          = (funct3 != 3'b010) && (funct3 != 3'b011);
                fmt            = IMM_B;
                ctrl.branch    = 1'b1;
                ctrl.rd        = 5'd0;
                ctrl.alu_sel_a = SEL_A_PC;
                ctrl.alu_sel_b = 1'b1;
            end
            OPC_LOAD: begin
                legal           = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                ctrl.load       = 1'b1;
                ctrl.mem_size   = mem_size_t'(funct3[1:0]);
                ctrl.mem_signed = ~funct3[2];
                ctrl.alu_sel_b  = 1'b1;
            end
            OPC_STORE: begin
                legal          = ~funct3[2] && (funct3[1:0] != 2'b11);
                fmt            = IMM_S;
                ctrl.store     = 1'b1;
                ctrl.mem_size  = mem_size_t'(funct3[1:0]);
                ctrl.rd        = 5'd0;
                ctrl.alu_sel_b = 1'b1;
            end
            OPC_OP_IMM: begin
                // Shift-immediates carry funct7 in imm[11:5]; other OP-IMM ops use the full imm.
                case (funct3)
                    3'b001:  legal = (funct7 == 7'h00);
                    3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: legal = 1'b1;
                endcase
                ctrl.alu_func  = alu_from_funct3(funct3, (funct3 == 3'b101) && instruction_in[30]);
                ctrl.alu_sel_b = 1'b1;
            end
            OPC_OP: begin
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                ctrl.alu_func = alu_from_funct3(funct3, instruction_in[30]);
            end
            OPC_MISC_MEM: begin
                legal   = (funct3[2:1] == 2'b00);
                ctrl.rd = 5'd0;
            end
            OPC_SYSTEM: begin
                ctrl.rd = 5'd0;
                if (funct3 == 3'b000) begin
                    legal = 1'b1;
                    case (instruction_in)
                        WORD_ECALL:  ctrl.ecall  = 1'b1;
                        WORD_EBREAK: ctrl.ebreak = 1'b1;
                        WORD_MRET:   ctrl.mret   = 1'b1;
                        WORD_WFI:    ctrl.wfi    = 1'b1;
                        default:     legal       = 1'b0;
                    endcase
                end else if (ENABLE_ZICSR && (funct3 != 3'b100)) begin
                    legal       = 1'b1;
                    ctrl.rd     = instruction_in[11:7];
                    ctrl.csr_op = csr_op_t'(funct3[1:0]);
                    if (funct3[2]) begin
                        fmt            = IMM_Z;
                        ctrl.alu_sel_b = 1'b1;
                    end
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctrl.rd      = 5'd0;
            ctrl.branch  = 1'b0;
            ctrl.jump    = 1'b0;
            ctrl.jalr    = 1'b0;
            ctrl.load    = 1'b0;
            ctrl.store   = 1'b0;
            ctrl.csr_op  = CSR_NONE;
            ctrl.ecall   = 1'b0;
            ctrl.ebreak  = 1'b0;
            ctrl.mret    = 1'b0;
            ctrl.wfi     = 1'b0;
            ctrl.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            pc_q       <= '0;
            next_pc_q  <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            cmp_q      <= '0;
            csr_addr_q <= '0;
            valid_q    <= 1'b0;
        end else if (stall) begin
            valid_q <= valid_q;
        end else if (invalidate) begin
            valid_q <= 1'b0;
        end else begin
            ctrl_q         <= ctrl;
            // A bubble must never raise a trap downstream.
            ctrl_q.illegal <= ctrl.illegal & valid_in;
            pc_q           <= pc_in;
            next_pc_q      <= next_pc_in;
            rs1_q          <= instruction_in[19:15];
            rs2_q          <= instruction_in[24:20];
            imm_q          <= imm;
            cmp_q          <= funct3;
            csr_addr_q     <= instruction_in[31:20];
            valid_q        <= valid_in;
        end
    end

    assign pc_out         = pc_q;
    assign next_pc_out    = next_pc_q;
    assign rs1_out        = rs1_q;
    assign rs2_out        = rs2_q;
    assign rd_out         = ctrl_q.rd;
    assign imm_out        = imm_q;
    assign alu_func_out   = ctrl_q.alu_func;
    assign alu_sel_a_out  = ctrl_q.alu_sel_a;
    assign alu_sel_b_out  = ctrl_q.alu_sel_b;
    assign cmp_func_out   = cmp_q;
    assign branch_out     = ctrl_q.branch;
    assign jump_out       = ctrl_q.jump;
    assign jalr_out       = ctrl_q.jalr;
    assign load_out       = ctrl_q.load;
    assign store_out      = ctrl_q.store;
    assign mem_size_out   = ctrl_q.mem_size;
    assign mem_signed_out = ctrl_q.mem_signed;
    assign csr_op_out     = ctrl_q.csr_op;
    assign csr_addr_out   = csr_addr_q;
    assign ecall_out      = ctrl_q.ecall;
    assign ebreak_out     = ctrl_q.ebreak;
    assign mret_out       = ctrl_q.mret;
    assign wfi_out        = ctrl_q.wfi;
    assign illegal_out    = ctrl_q.illegal;
    assign valid_out      = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decode : directed and randomized checks of the decode stage             |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
module tb_decode;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0, next_pc_in = '0, instruction_in = '0;
    logic        valid_in = 1'b0, stall = 1'b0, invalidate = 1'b0;
    logic [4:0]  rs1_address, rs2_address, rs1_out, rs2_out, rd_out;
    logic [31:0] pc_out, next_pc_out, imm_out;
    logic [3:0]  alu_func_out;
    logic [1:0]  alu_sel_a_out, mem_size_out, csr_op_out;
    logic [2:0]  cmp_func_out;
    logic [11:0] csr_addr_out;
    logic        alu_sel_b_out, branch_out, jump_out, jalr_out, load_out, store_out;
    logic        mem_signed_out, ecall_out, ebreak_out, mret_out, wfi_out, illegal_out, valid_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode #(.XLEN(32), .ENABLE_ZICSR(1'b1)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc_in(next_pc_in),
        .instruction_in(instruction_in), .valid_in(valid_in), .stall(stall),
        .invalidate(invalidate), .rs1_address(rs1_address), .rs2_address(rs2_address),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .rd_out(rd_out), .imm_out(imm_out), .alu_func_out(alu_func_out),
        .alu_sel_a_out(alu_sel_a_out), .alu_sel_b_out(alu_sel_b_out),
        .cmp_func_out(cmp_func_out), .branch_out(branch_out), .jump_out(jump_out),
        .jalr_out(jalr_out), .load_out(load_out), .store_out(store_out),
        .mem_size_out(mem_size_out), .mem_signed_out(mem_signed_out),
        .csr_op_out(csr_op_out), .csr_addr_out(csr_addr_out), .ecall_out(ecall_out),
        .ebreak_out(ebreak_out), .mret_out(mret_out), .wfi_out(wfi_out),
        .illegal_out(illegal_out), .valid_out(valid_out)
    );

    logic [203:0] all_outs;
    assign all_outs = {pc_out, next_pc_out, rs1_out, rs2_out, rd_out, imm_out, alu_func_out,
                       alu_sel_a_out, alu_sel_b_out, cmp_func_out, branch_out, jump_out,
                       jalr_out, load_out, store_out, mem_size_out, mem_signed_out, csr_op_out,
                       csr_addr_out, ecall_out, ebreak_out, mret_out, wfi_out, illegal_out,
                       valid_out};

    logic [9:0] side_fx;
    assign side_fx = {branch_out, jump_out, jalr_out, load_out, store_out, ecall_out,
                      ebreak_out, mret_out, wfi_out, |csr_op_out};

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        imm_chk;
        logic [3:0]  alu;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        alu_chk;
        logic        branch, jump, jalr, load, store;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  csr_op;
        logic        ecall, ebreak, mret, wfi, illegal;
    } exp_t;

    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                              7'h13, 7'h33, 7'h0F, 7'h73};

    // Reference decoder written straight from the ISA tables.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        logic [3:0] tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.rd = w[11:7];
        ok = 1'b0;
        case (w[6:0])
            7'h37, 7'h17: begin
                ok = 1'b1; e.imm = {w[31:12], 12'h0}; e.imm_chk = 1'b1;
                e.alu = ALU_ADD; e.sel_a = (w[5] ? 2'd2 : 2'd1); e.sel_b = 1'b1; e.alu_chk = 1'b1;
            end
            7'h6F: begin
                ok = 1'b1; e.jump = 1'b1; e.imm_chk = 1'b1;
                e.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: begin
                ok = (f3 == 0); e.jump = 1'b1; e.jalr = 1'b1; e.imm_chk = 1'b1;
                e.imm = {{20{w[31]}}, w[31:20]};
            end
            7'h63: begin
                ok = (f3 != 2) && (f3 != 3); e.branch = 1'b1; e.rd = 0; e.imm_chk = 1'b1;
                e.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h03: begin
                ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
                e.load = 1'b1; e.size = f3[1:0]; e.sgn = (f3 < 4); e.imm_chk = 1'b1;
                e.imm = {{20{w[31]}}, w[31:20]};
                e.alu = ALU_ADD; e.sel_a = 0; e.sel_b = 1'b1; e.alu_chk = 1'b1;
            end
            7'h23: begin
                ok = (f3 < 3); e.store = 1'b1; e.size = f3[1:0]; e.rd = 0; e.imm_chk = 1'b1;
                e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'h13: begin
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                e.alu = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : tbl[f3];
                e.sel_a = 0; e.sel_b = 1'b1; e.alu_chk = 1'b1; e.imm_chk = 1'b1;
                e.imm = {{20{w[31]}}, w[31:20]};
            end
            7'h33: begin
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.alu = (f7 == 7'h20) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : tbl[f3];
                e.sel_a = 0; e.sel_b = 1'b0; e.alu_chk = 1'b1;
            end
            7'h0F: begin
                ok = (f3 < 2); e.rd = 0;
            end
            7'h73: begin
                if (f3 == 0) begin
                    e.rd = 0;
                    e.ecall  = (w == 32'h00000073);
                    e.ebreak = (w == 32'h00100073);
                    e.mret   = (w == 32'h30200073);
                    e.wfi    = (w == 32'h10500073);
                    ok = e.ecall | e.ebreak | e.mret | e.wfi;
                end else if (f3 != 4) begin
                    ok = 1'b1; e.csr_op = f3[1:0];
                    if (f3 >= 4) begin
                        e.imm = {27'd0, w[19:15]}; e.imm_chk = 1'b1; e.sel_b = 1'b1;
                    end
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k <= 10) begin
            r[6:0] = opcs[k];
            if ((k == 7 || k == 8) && $urandom_range(0, 9) < 7)
                r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (k == 11) begin
            case ($urandom_range(0, 3))
                0: r = 32'h00000073;
                1: r = 32'h00100073;
                2: r = 32'h30200073;
                default: r = 32'h10500073;
            endcase
        end else if (k == 12) begin
            r[6:0] = 7'h73;
            r[14:12] = 3'($urandom_range(1, 7));
        end else if (k == 13) begin
            r[6:0] = opcs[$urandom_range(0, 10)];
            r[1:0] = 2'($urandom_range(0, 2));
        end
        return r;
    endfunction

    task automatic drive(input logic [31:0] w, input logic [31:0] pc, input logic v,
                         input logic st, input logic inv);
        instruction_in = w;
        pc_in = pc;
        next_pc_in = pc + 32'd4;
        valid_in = v;
        stall = st;
        invalidate = inv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stall = 1'b1;
        invalidate = 1'b1;
        valid_in = 1'b1;
        instruction_in = 32'hFFB10093;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        drive(32'hFFB10093, 32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({rd_out, rs1_out, valid_out} !== {5'd1, 5'd2, 1'b1}) begin
            failures++;
            $display("FAIL addi_regs: got rd=%0d rs1=%0d v=%b required rd=1 rs1=2 v=1",
                     rd_out, rs1_out, valid_out);
        end
        checks++;
        if ({imm_out, alu_func_out, alu_sel_b_out} !== {32'hFFFFFFFB, 4'(ALU_ADD), 1'b1}) begin
            failures++;
            $display("FAIL addi_imm_alu: got imm=%h alu=%0d b=%b required fffffffb 0 1",
                     imm_out, alu_func_out, alu_sel_b_out);
        end
        checks++;
        if ({pc_out, next_pc_out} !== {32'h100, 32'h104}) begin
            failures++;
            $display("FAIL addi_pc: got %h %h required 100 104", pc_out, next_pc_out);
        end
    endtask

    task automatic test_branch_store_lui();
        drive(32'hFE208CE3, 32'h200, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({branch_out, cmp_func_out, imm_out, rd_out} !== {1'b1, 3'b000, 32'hFFFFFFF8, 5'd0}) begin
            failures++;
            $display("FAIL beq: got br=%b cmp=%0d imm=%h rd=%0d required 1 0 fffffff8 0",
                     branch_out, cmp_func_out, imm_out, rd_out);
        end
        drive(32'h00312623, 32'h204, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({store_out, mem_size_out, imm_out, rd_out} !== {1'b1, 2'd2, 32'd12, 5'd0}) begin
            failures++;
            $display("FAIL sw: got st=%b size=%0d imm=%h rd=%0d required 1 2 c 0",
                     store_out, mem_size_out, imm_out, rd_out);
        end
        drive(32'h123452B7, 32'h208, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({imm_out, alu_sel_a_out, rd_out} !== {32'h12345000, 2'd2, 5'd5}) begin
            failures++;
            $display("FAIL lui: got imm=%h a=%0d rd=%0d required 12345000 2 5",
                     imm_out, alu_sel_a_out, rd_out);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words [3] = '{32'h00000000, 32'h4000C0B3, 32'h0200D0B3};
        for (int i = 0; i < 3; i++) begin
            drive(words[i], 32'h300, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({illegal_out, valid_out, side_fx, rd_out} !== {1'b1, 1'b1, 10'd0, 5'd0}) begin
                failures++;
                $display("FAIL illegal_%0d: got ill=%b v=%b fx=%b rd=%0d required 1 1 0 0",
                         i, illegal_out, valid_out, side_fx, rd_out);
            end
        end
        drive(32'h30200073, 32'h304, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({mret_out, illegal_out, rd_out} !== {1'b1, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL mret: got mret=%b ill=%b rd=%0d required 1 0 0",
                     mret_out, illegal_out, rd_out);
        end
        drive(32'h00000000, 32'h308, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({valid_out, illegal_out} !== 2'b00) begin
            failures++;
            $display("FAIL bubble: got v=%b ill=%b required 0 0", valid_out, illegal_out);
        end
    endtask

    task automatic test_stall_invalidate();
        drive(32'hFFB10093, 32'h400, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(32'h00312623 + 32'(i << 7), 32'h404, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({valid_out, rd_out, imm_out, pc_out} !== {1'b1, 5'd1, 32'hFFFFFFFB, 32'h400}) begin
                failures++;
                $display("FAIL stall_hold_%0d: got v=%b rd=%0d imm=%h pc=%h required 1 1 fffffffb 400",
                         i, valid_out, rd_out, imm_out, pc_out);
            end
        end
        drive(32'h00312623, 32'h404, 1'b1, 1'b0, 1'b1);
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL invalidate: got v=%b required 0", valid_out);
        end
        drive(32'h123452B7, 32'h500, 1'b1, 1'b0, 1'b0);
        drive(32'hFE208CE3, 32'h504, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({valid_out, rd_out, imm_out, branch_out} !== {1'b1, 5'd5, 32'h12345000, 1'b0}) begin
            failures++;
            $display("FAIL stall_over_invalidate: got v=%b rd=%0d imm=%h br=%b required 1 5 12345000 0",
                     valid_out, rd_out, imm_out, branch_out);
        end
    endtask

    task automatic test_midstream_reset();
        drive(32'hFFB10093, 32'h600, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        drive(32'h00312623, 32'h604, 1'b1, 1'b1, 1'b0);
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL midstream_reset: got %h required 0", all_outs);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        exp_t e = '0;
        logic [31:0] epc = '0, w, pc;
        logic [4:0]  ers1 = '0, ers2 = '0;
        logic [11:0] ecsr = '0;
        logic ev = 1'b0, known = 1'b0, bubble = 1'b0, v, st, inv;
        for (int n = 0; n < 600; n++) begin
            w   = gen_instr();
            pc  = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            v   = ($urandom_range(0, 9) < 9);
            st  = (n > 0) && ($urandom_range(0, 9) < 2);
            inv = (n > 0) && ($urandom_range(0, 9) < 2);
            instruction_in = w; pc_in = pc; next_pc_in = pc + 32'd4;
            valid_in = v; stall = st; invalidate = inv;
            #1;
            checks++;
            if ({rs1_address, rs2_address} !== {w[19:15], w[24:20]}) begin
                failures++;
                $display("FAIL rnd_addr: got %0d %0d required %0d %0d",
                         rs1_address, rs2_address, w[19:15], w[24:20]);
            end
            @(posedge clk);
            #1;
            if (!st) begin
                if (inv) begin
                    ev = 1'b0; known = 1'b0; bubble = 1'b0;
                end else begin
                    ev = v; known = v; bubble = !v;
                    if (v) begin
                        e = model(w); epc = pc; ers1 = w[19:15]; ers2 = w[24:20]; ecsr = w[31:20];
                    end
                end
            end
            checks++;
            if (valid_out !== ev) begin
                failures++;
                $display("FAIL rnd_valid: cycle %0d got %b required %b", n, valid_out, ev);
            end
            if (bubble) begin
                checks++;
                if (illegal_out !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_bubble_illegal: got %b required 0", illegal_out);
                end
            end
            if (known) begin
                checks++;
                if ({pc_out, next_pc_out, rs1_out, rs2_out} !== {epc, epc + 32'd4, ers1, ers2}) begin
                    failures++;
                    $display("FAIL rnd_pc_regs: instr %h got %h %h %0d %0d required %h %h %0d %0d",
                             w, pc_out, next_pc_out, rs1_out, rs2_out, epc, epc + 32'd4, ers1, ers2);
                end
                checks++;
                if ({rd_out, illegal_out, branch_out, jump_out, jalr_out, load_out, store_out,
                     csr_op_out, ecall_out, ebreak_out, mret_out, wfi_out} !==
                    {e.rd, e.illegal, e.branch, e.jump, e.jalr, e.load, e.store,
                     e.csr_op, e.ecall, e.ebreak, e.mret, e.wfi}) begin
                    failures++;
                    $display("FAIL rnd_ctrl: rd=%0d ill=%b fx=%b csr=%0d required rd=%0d ill=%b br=%b j=%b jr=%b ld=%b st=%b csr=%0d sys=%b%b%b%b",
                             rd_out, illegal_out, side_fx, csr_op_out, e.rd, e.illegal, e.branch,
                             e.jump, e.jalr, e.load, e.store, e.csr_op, e.ecall, e.ebreak, e.mret, e.wfi);
                end
                if (e.imm_chk) begin
                    checks++;
                    if (imm_out !== e.imm) begin
                        failures++;
                        $display("FAIL rnd_imm: got %h required %h", imm_out, e.imm);
                    end
                end
                if (e.alu_chk) begin
                    checks++;
                    if ({alu_func_out, alu_sel_a_out, alu_sel_b_out} !== {e.alu, e.sel_a, e.sel_b}) begin
                        failures++;
                        $display("FAIL rnd_alu: got %0d %0d %b required %0d %0d %b",
                                 alu_func_out, alu_sel_a_out, alu_sel_b_out, e.alu, e.sel_a, e.sel_b);
                    end
                end
                if (e.branch) begin
                    checks++;
                    if (cmp_func_out !== w[14:12] && !st) begin
                        failures++;
                        $display("FAIL rnd_cmp: got %0d required %0d", cmp_func_out, w[14:12]);
                    end
                end
                if (e.load || e.store) begin
                    checks++;
                    if (mem_size_out !== e.size || (e.load && mem_signed_out !== e.sgn)) begin
                        failures++;
                        $display("FAIL rnd_mem: got size=%0d sgn=%b required %0d %b",
                                 mem_size_out, mem_signed_out, e.size, e.sgn);
                    end
                end
                if (e.csr_op != 2'd0) begin
                    checks++;
                    if ({csr_addr_out, alu_sel_b_out} !== {ecsr, e.sel_b}) begin
                        failures++;
                        $display("FAIL rnd_csr: got addr=%h b=%b required %h %b",
                                 csr_addr_out, alu_sel_b_out, ecsr, e.sel_b);
                    end
                end
            end
        end
        stall = 1'b0;
        invalidate = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch_store_lui();
        test_illegal();
        test_stall_invalidate();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
